// File: rtl/zigzag_buf.sv
// Zig-zag reorder buffer: raster-order 8x8 coefficient blocks in,
// JPEG zig-zag order out, ping-pong banked so write and read overlap.
//
// Ports:
//   clk, nrst      clock (rising edge), asynchronous active-low reset
//   din/din_valid  raster-order coefficients from the quantizer (no stall)
//   dout/dout_valid/dout_ready  zig-zag-order output, valid/ready handshake
//   dout_last      marks zig-zag index 63 of each block
//   overflow       sticky flag, set when an input sample had to be dropped
module zigzag_buf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic          overflow
);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    // zig-zag index -> raster address
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // ------------------------------------------------------------
    // Storage: bank in address MSB, raster position below
    // ------------------------------------------------------------
    logic [DW-1:0] mem [128];

    // ------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------
    logic [5:0] wr_cnt;
    logic       wr_bank;
    logic [1:0] full;
    logic       wr_en;
    logic       wr_done;
    logic       wr_drop;

    assign wr_en   = din_valid & ~full[wr_bank];
    assign wr_drop = din_valid &  full[wr_bank];
    assign wr_done = wr_en & (wr_cnt == 6'd63);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_cnt}] <= din;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_cnt   <= '0;
            wr_bank  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_cnt <= wr_cnt + 6'd1;
            end
            if (wr_done) begin
                wr_bank <= ~wr_bank;
            end
            if (wr_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------
    state_t        state;
    state_t        state_n;
    logic [5:0]    rd_cnt;
    logic          rd_bank;
    logic          issue;
    logic          rd_done;
    logic [DW-1:0] rd_word;

    // Pipeline: fetch register -> skid register -> output register.
    logic [DW-1:0] r_data;
    logic          r_last;
    logic          r_valid;
    logic [DW-1:0] sk_data;
    logic          sk_last;
    logic          sk_valid;

    logic [DW-1:0] r_data_n;
    logic          r_last_n;
    logic          r_valid_n;
    logic [DW-1:0] sk_data_n;
    logic          sk_last_n;
    logic          sk_valid_n;
    logic [DW-1:0] dout_n;
    logic          dout_last_n;
    logic          dout_valid_n;
    logic          advance;

    // A fetch only needs an empty skid slot: whatever sits in the
    // fetch register this cycle can always move to dout or the skid,
    // so dout_ready never reaches the memory address path.
    // The first fetch of a block overlaps the IDLE->READ decision so
    // a bank is released early enough for gapless continuous input.
    assign issue   = full[rd_bank] & ~sk_valid;
    assign rd_done = issue & (rd_cnt == 6'd63);
    assign rd_word = mem[{rd_bank, ZZ[rd_cnt]}];
    assign advance = ~dout_valid | dout_ready;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_n = READ;
                end
            end
            READ: begin
                if (rd_done) begin
                    state_n = full[~rd_bank] ? READ : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else begin
            state <= state_n;
            if (issue) begin
                rd_cnt <= rd_cnt + 6'd1;
            end
            if (rd_done) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Write and read sides own separate events on the flag pair;
    // merging them here keeps simultaneous set/clear from being lost.
    logic [1:0] full_set;
    logic [1:0] full_clr;

    always_comb begin
        full_set = 2'b00;
        full_clr = 2'b00;
        full_set[wr_bank] = wr_done;
        full_clr[rd_bank] = rd_done;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            full <= 2'b00;
        end else begin
            full <= (full | full_set) & ~full_clr;
        end
    end

    // ------------------------------------------------------------
    // Output pipeline next-state
    // ------------------------------------------------------------
    always_comb begin
        r_data_n     = r_data;
        r_last_n     = r_last;
        r_valid_n    = r_valid;
        sk_data_n    = sk_data;
        sk_last_n    = sk_last;
        sk_valid_n   = sk_valid;
        dout_n       = dout;
        dout_last_n  = dout_last;
        dout_valid_n = dout_valid;

        if (advance) begin
            if (sk_valid) begin
                dout_n       = sk_data;
                dout_last_n  = sk_last;
                dout_valid_n = 1'b1;
                sk_data_n    = r_data;
                sk_last_n    = r_last;
                sk_valid_n   = r_valid;
            end else if (r_valid) begin
                dout_n       = r_data;
                dout_last_n  = r_last;
                dout_valid_n = 1'b1;
            end else begin
                dout_last_n  = 1'b0;
                dout_valid_n = 1'b0;
            end
        end else if (!sk_valid && r_valid) begin
            sk_data_n  = r_data;
            sk_last_n  = r_last;
            sk_valid_n = 1'b1;
        end

        // Fetch register is consumed unless it is stuck behind a
        // full skid with a stalled output.
        if (!sk_valid || advance) begin
            r_valid_n = 1'b0;
        end

        if (issue) begin
            r_data_n  = rd_word;
            r_last_n  = (rd_cnt == 6'd63);
            r_valid_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_data     <= '0;
            r_last     <= 1'b0;
            r_valid    <= 1'b0;
            sk_data    <= '0;
            sk_last    <= 1'b0;
            sk_valid   <= 1'b0;
            dout       <= '0;
            dout_last  <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            r_data     <= r_data_n;
            r_last     <= r_last_n;
            r_valid    <= r_valid_n;
            sk_data    <= sk_data_n;
            sk_last    <= sk_last_n;
            sk_valid   <= sk_valid_n;
            dout       <= dout_n;
            dout_last  <= dout_last_n;
            dout_valid <= dout_valid_n;
        end
    end

endmodule
